// File: rtl/messbauer_diff_discriminator_generator.sv
// ---------------------------------------------------------------------------
// messbauer_diff_discriminator_generator
//
// Purpose: produces test bursts for a Moessbauer differential discriminator.
// Each rising edge on the asynchronous `channel` strobe (while idle and
// enabled) starts one burst of IMPULSES_PER_CHANNEL impulses. Every impulse
// raises lower_threshold for LOWER_DURATION cycles. Impulses from index
// IMPULSES_FOR_SELECTION onward also raise upper_threshold for
// UPPER_DURATION cycles, starting one cycle after lower rises. Each impulse
// is followed by PAUSE_DURATION cycles with both levels low. A final single
// cycle (DONE) pulses channel_done and advances channel_index. cycle_done
// marks the last channel of a measurement cycle.
//
// Ports:
//   aclk            in   clock
//   areset_n        in   asynchronous active-low reset
//   enable          in   1 = accept new channel strobes (gates burst start only)
//   channel         in   asynchronous channel-advance strobe, rising edge active
//   lower_threshold out  lower discriminator level
//   upper_threshold out  upper discriminator level
//   busy            out  burst in progress
//   channel_done    out  one-cycle pulse at end of each burst
//   cycle_done      out  one-cycle pulse at end of last burst of a cycle
//   channel_index   out  index of current/next burst, 0..CHANNELS_PER_CYCLE-1
//   overrun         out  sticky; strobe arrived while busy
// ---------------------------------------------------------------------------
module messbauer_diff_discriminator_generator #(
  parameter int LOWER_DURATION         = 3,
  parameter int UPPER_DURATION         = 1,
  parameter int PAUSE_DURATION         = 10,
  parameter int IMPULSES_PER_CHANNEL   = 16,
  parameter int IMPULSES_FOR_SELECTION = 4,
  parameter int CHANNELS_PER_CYCLE     = 4,
  parameter int CNT_W                  = 8
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             enable,
  input  logic             channel,
  output logic             lower_threshold,
  output logic             upper_threshold,
  output logic             busy,
  output logic             channel_done,
  output logic             cycle_done,
  output logic [CNT_W-1:0] channel_index,
  output logic             overrun
);

  // Illegal parameter sets stop elaboration.
  generate
    if (UPPER_DURATION < 1 ||
        LOWER_DURATION < UPPER_DURATION + 2 ||
        PAUSE_DURATION < 1 ||
        IMPULSES_PER_CHANNEL < 1 ||
        CHANNELS_PER_CYCLE < 1 ||
        IMPULSES_FOR_SELECTION < 0 ||
        IMPULSES_FOR_SELECTION >= IMPULSES_PER_CHANNEL ||
        LOWER_DURATION >= (1 << CNT_W) ||
        UPPER_DURATION >= (1 << CNT_W) ||
        PAUSE_DURATION >= (1 << CNT_W) ||
        IMPULSES_PER_CHANNEL >= (1 << CNT_W) ||
        CHANNELS_PER_CYCLE >= (1 << CNT_W)) begin : g_bad_params
      $error("messbauer_diff_discriminator_generator: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    LOWER_LEAD,
    UPPER_HIGH,
    LOWER_TAIL,
    PAUSE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_UPPER_LAST  = CNT_W'(UPPER_DURATION - 1);
  // LOWER_TAIL length: the rest of the lower pulse after LOWER_LEAD (and
  // after UPPER_HIGH when the impulse carries an upper pulse).
  localparam logic [CNT_W-1:0] C_TAIL_NOUP   = CNT_W'(LOWER_DURATION - 2);
  localparam logic [CNT_W-1:0] C_TAIL_UP     = CNT_W'(LOWER_DURATION - UPPER_DURATION - 2);
  localparam logic [CNT_W-1:0] C_PAUSE_LAST  = CNT_W'(PAUSE_DURATION - 1);
  localparam logic [CNT_W-1:0] C_IMP_LAST    = CNT_W'(IMPULSES_PER_CHANNEL - 1);
  localparam logic [CNT_W-1:0] C_CH_LAST     = CNT_W'(CHANNELS_PER_CYCLE - 1);
  localparam logic [CNT_W:0]   C_SEL         = (CNT_W+1)'(IMPULSES_FOR_SELECTION);

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_imp;
  logic [CNT_W-1:0] r_index;
  logic             r_overrun;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_imp_next;
  logic [CNT_W-1:0] w_index_next;
  logic             w_overrun_next;
  logic             w_edge;
  logic             w_upper_imp;
  logic [CNT_W:0]   w_imp_plus1;
  logic [CNT_W-1:0] w_tail_last;

  // r_sync1/r_sync2 resynchronise the strobe; r_sync3 is the previous
  // synchronised value used for rising-edge detection.
  assign w_edge = r_sync2 & ~r_sync3;

  // "index >= IMPULSES_FOR_SELECTION" written as "index+1 > SEL" so the
  // comparison stays meaningful when SEL is zero.
  assign w_imp_plus1 = {1'b0, r_imp} + {{CNT_W{1'b0}}, 1'b1};
  assign w_upper_imp = (w_imp_plus1 > C_SEL);
  assign w_tail_last = w_upper_imp ? C_TAIL_UP : C_TAIL_NOUP;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_cnt     <= '0;
      r_imp     <= '0;
      r_index   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sync1   <= channel;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_cnt     <= w_cnt_next;
      r_imp     <= w_imp_next;
      r_index   <= w_index_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_imp_next      = r_imp;
    w_index_next    = r_index;
    // Any strobe outside IDLE (DONE included) is discarded and flagged.
    w_overrun_next  = r_overrun | (w_edge & (r_state != IDLE));
    lower_threshold = 1'b0;
    upper_threshold = 1'b0;
    busy            = (r_state != IDLE);
    channel_done    = 1'b0;
    cycle_done      = 1'b0;
    channel_index   = r_index;
    overrun         = r_overrun;

    case (r_state)
      IDLE: begin
        if (w_edge && enable) begin
          w_state_next = LOWER_LEAD;
          w_cnt_next   = '0;
          w_imp_next   = '0;
        end
      end
      LOWER_LEAD: begin
        lower_threshold = 1'b1;
        w_cnt_next      = '0;
        w_state_next    = w_upper_imp ? UPPER_HIGH : LOWER_TAIL;
      end
      UPPER_HIGH: begin
        lower_threshold = 1'b1;
        upper_threshold = 1'b1;
        if (r_cnt == C_UPPER_LAST) begin
          w_cnt_next   = '0;
          w_state_next = LOWER_TAIL;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      LOWER_TAIL: begin
        lower_threshold = 1'b1;
        if (r_cnt == w_tail_last) begin
          w_cnt_next   = '0;
          w_state_next = PAUSE;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      PAUSE: begin
        if (r_cnt == C_PAUSE_LAST) begin
          w_cnt_next = '0;
          if (r_imp == C_IMP_LAST) begin
            w_state_next = DONE;
          end else begin
            w_imp_next   = r_imp + C_ONE;
            w_state_next = LOWER_LEAD;
          end
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      DONE: begin
        channel_done = 1'b1;
        cycle_done   = (r_index == C_CH_LAST);
        w_index_next = (r_index == C_CH_LAST) ? '0 : r_index + C_ONE;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
